// File: rtl/adc_rx_pkg.sv
// adc_rx_pkg: shared widths, receive FSM states and the offset-binary to sfix18 mapping.
package adc_rx_pkg;
    localparam int SAMPLE_W = 18;
    localparam int ADC_W = 16;
    localparam int MAG_W = 17;

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLDOFF} state_t;

    function automatic logic [SAMPLE_W-1:0] adc_to_sample(input logic [ADC_W-1:0] a);
        return {~a[ADC_W-1], ~a[ADC_W-1], a[ADC_W-2:0], 1'b0};
    endfunction
endpackage

// File: rtl/rx_fwft_fifo.sv
// rx_fwft_fifo: first-word-fall-through FIFO; output holds the last popped word while empty.
module rx_fwft_fifo #(
    parameter int W = 18,
    parameter int LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LOG2:0] count
);
    localparam int DEPTH = 1 << LOG2;

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] hold;
    logic [LOG2:0] wptr, rptr;
    logic do_push, do_pop;

    assign count = wptr - rptr;
    assign empty = wptr == rptr;
    assign full = count[LOG2];
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = empty ? hold : mem[rptr[LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[LOG2-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            hold <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) begin
                rptr <= rptr + 1'b1;
                hold <= mem[rptr[LOG2-1:0]];
            end
        end
    end
endmodule

// File: rtl/adc_rx_frontend.sv
// adc_rx_frontend: ADC sample recovery, moving-sum burst detect, fixed-length burst capture into a FWFT FIFO.
module adc_rx_frontend
    import adc_rx_pkg::*;
#(
    parameter int WIN_LOG2 = 4,
    parameter int FIFO_LOG2 = 4,
    parameter int SUM_W = 17 + WIN_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADC_W-1:0]    adc_data,
    input  logic                adc_valid,
    input  logic [SUM_W-1:0]    thresh,
    input  logic [15:0]         burst_len,
    input  logic                rx_ready,
    output logic [SAMPLE_W-1:0] rxData_re,
    output logic                rxValid,
    output logic                burst_start,
    output logic                busy,
    output logic                overflow
);
    localparam int WIN = 1 << WIN_LOG2;
    localparam logic [WIN_LOG2:0] WIN_FULL = {1'b1, {WIN_LOG2{1'b0}}};

    logic [SAMPLE_W-1:0] s1_x, s2_x, s3_x;
    logic s1_v, s2_v, s3_v, s2_armed, s3_hit;
    logic [MAG_W-1:0] dline [WIN];
    logic [MAG_W-1:0] mag;
    logic [SUM_W-1:0] sum;
    logic [WIN_LOG2:0] fill;
    state_t state, state_n;
    logic [15:0] cnt, cnt_n, blen, blen_n;
    logic [WIN_LOG2-1:0] hcnt, hcnt_n;
    logic wr, trig, pop;
    logic fifo_full, fifo_empty;
    logic [FIFO_LOG2:0] fifo_count;

    assign mag = s1_x[SAMPLE_W-1] ? MAG_W'(-s1_x) : MAG_W'(s1_x);
    assign busy = state != IDLE;
    assign rxValid = !fifo_empty;
    assign pop = rx_ready && fifo_count != '0;

    // s2_armed uses the fill count before this sample, so the window must already be full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
            s1_x <= '0;
            s2_x <= '0;
            s3_x <= '0;
            s2_armed <= 1'b0;
            s3_hit <= 1'b0;
            sum <= '0;
            fill <= '0;
            for (int i = 0; i < WIN; i++) dline[i] <= '0;
        end else begin
            s1_v <= adc_valid;
            if (adc_valid) s1_x <= adc_to_sample(adc_data);
            s2_v <= s1_v;
            if (s1_v) begin
                s2_x <= s1_x;
                s2_armed <= fill == WIN_FULL;
                sum <= sum + SUM_W'(mag) - SUM_W'(dline[WIN-1]);
                fill <= fill == WIN_FULL ? fill : fill + 1'b1;
                dline[0] <= mag;
                for (int i = 1; i < WIN; i++) dline[i] <= dline[i-1];
            end
            s3_v <= s2_v;
            if (s2_v) begin
                s3_x <= s2_x;
                s3_hit <= s2_armed && sum >= thresh;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        blen_n = blen;
        hcnt_n = hcnt;
        wr = 1'b0;
        trig = 1'b0;
        if (s3_v) begin
            case (state)
                IDLE: if (s3_hit) begin
                    trig = 1'b1;
                    wr = 1'b1;
                    cnt_n = 16'd1;
                    hcnt_n = '0;
                    blen_n = burst_len == 16'd0 ? 16'd1 : burst_len;
                    state_n = blen_n == 16'd1 ? HOLDOFF : CAPTURE;
                end
                CAPTURE: begin
                    wr = 1'b1;
                    cnt_n = cnt + 16'd1;
                    state_n = cnt_n == blen ? HOLDOFF : CAPTURE;
                end
                HOLDOFF: begin
                    hcnt_n = hcnt + 1'b1;
                    state_n = &hcnt ? IDLE : HOLDOFF;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            blen <= 16'd1;
            hcnt <= '0;
            burst_start <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            blen <= blen_n;
            hcnt <= hcnt_n;
            burst_start <= trig;
            overflow <= (overflow && !trig) || (wr && fifo_full && !pop);
        end
    end

    rx_fwft_fifo #(.W(SAMPLE_W), .LOG2(FIFO_LOG2)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(wr),
        .pop(pop),
        .din(s3_x),
        .dout(rxData_re),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );
endmodule

// File: tb/tb_adc_rx_frontend.sv
// tb_adc_rx_frontend: directed vectors with hand-computed expectations for adc_rx_frontend.
module tb_adc_rx_frontend;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] adc_data = '0;
    logic adc_valid = 1'b0;
    logic [20:0] thresh = '0;
    logic [15:0] burst_len = '0;
    logic rx_ready = 1'b0;
    logic [17:0] rxData_re;
    logic rxValid, burst_start, busy, overflow;
    int errors = 0;
    int checks = 0;

    adc_rx_frontend dut (
        .clk(clk),
        .rst(rst),
        .adc_data(adc_data),
        .adc_valid(adc_valid),
        .thresh(thresh),
        .burst_len(burst_len),
        .rx_ready(rx_ready),
        .rxData_re(rxData_re),
        .rxValid(rxValid),
        .burst_start(burst_start),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        adc_valid = v;
        adc_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        adc_valid = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int nbs, nv, first, second, b37, b38;
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom));
        check("rst_data", rxData_re, 0);
        check("rst_valid", rxValid, 0);
        check("rst_bs", burst_start, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);

        // quiet input never reaches thresh=1
        thresh = 21'd1; burst_len = 16'd3; rx_ready = 1'b1;
        rst = 1'b1;
        nbs = 0; nv = 0;
        for (int i = 0; i < 24; i++) begin
            step(i < 20, 16'h8000);
            nbs += int'(burst_start);
            nv += int'(rxValid);
        end
        check("quiet_bs", nbs, 0);
        check("quiet_valid", nv, 0);

        // conversion and first-write latency
        do_reset();
        thresh = 21'd0;
        for (int i = 0; i < 16; i++) step(1'b1, 16'h8000);
        step(1'b1, 16'hFFFF);
        check("lat_k0_valid", rxValid, 0);
        step(1'b1, 16'h0000);
        check("lat_k1_valid", rxValid, 0);
        step(1'b1, 16'h8001);
        check("lat_k2_valid", rxValid, 0);
        check("lat_k2_bs", burst_start, 0);
        step(1'b0, 16'h0);
        check("conv_valid", rxValid, 1);
        check("conv_bs", burst_start, 1);
        check("conv_busy", busy, 1);
        check("conv_ffff", rxData_re, 32'h0FFFE);
        step(1'b0, 16'h0);
        check("conv_0000", rxData_re, 32'h30000);
        check("conv_bs_drop", burst_start, 0);
        step(1'b0, 16'h0);
        check("conv_8001", rxData_re, 32'h2);
        step(1'b0, 16'h0);
        check("conv_empty", rxValid, 0);
        check("conv_hold", rxData_re, 32'h2);

        // threshold equal to window sum triggers; burst_len 0 acts as 1
        do_reset();
        thresh = 21'd8192; burst_len = 16'd0;
        nbs = 0; nv = 0; first = -1;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 16'h8100);
            if (burst_start && first < 0) first = i;
            nbs += int'(burst_start);
            nv += int'(rxValid);
        end
        check("thr_eq_first", first, 19);
        check("thr_eq_count", nbs, 1);
        check("blen0_outputs", nv, 1);
        do_reset();
        thresh = 21'd8193;
        nbs = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'h8100);
            nbs += int'(burst_start);
        end
        check("thr_above", nbs, 0);

        // holdoff spacing; mid-burst burst_len change ignored
        do_reset();
        thresh = 21'd1000; burst_len = 16'd4;
        nv = 0; first = -1; second = -1; b37 = 0; b38 = 1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'hFFFF);
            if (i == 20) burst_len = 16'd100;
            if (burst_start) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (i < 39) nv += int'(rxValid);
            if (i == 37) b37 = int'(busy);
            if (i == 38) b38 = int'(busy);
        end
        check("hold_first", first, 19);
        check("hold_second", second, 39);
        check("hold_outputs", nv, 4);
        check("hold_busy37", b37, 1);
        check("hold_busy38", b38, 0);

        // backpressure and overflow
        do_reset();
        burst_len = 16'd40; rx_ready = 1'b0;
        for (int i = 0; i < 75; i++) begin
            step(i < 72, 16'hC000 + 16'(i));
            if (i == 34) check("ovf_before", overflow, 0);
            if (i == 35) check("ovf_set", overflow, 1);
            if (i == 73) check("bp_busy73", busy, 1);
            if (i == 74) check("bp_busy74", busy, 0);
        end
        check("bp_valid", rxValid, 1);
        check("bp_ovf_sticky", overflow, 1);
        rx_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check($sformatf("drain%0d", j), rxData_re, 32'h08000 + 32'(2 * (16 + j)));
            step(1'b0, 16'h0);
        end
        check("drain_empty", rxValid, 0);
        burst_len = 16'd1;
        step(1'b1, 16'hC000);
        step(1'b0, 16'h0);
        step(1'b0, 16'h0);
        check("ovf_hold", overflow, 1);
        step(1'b0, 16'h0);
        check("rebs", burst_start, 1);
        check("ovf_clear", overflow, 0);

        // asynchronous reset mid-capture
        do_reset();
        burst_len = 16'd40; rx_ready = 1'b0;
        for (int i = 0; i < 25; i++) step(1'b1, 16'hFFFF);
        check("mid_busy", busy, 1);
        check("mid_valid", rxValid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", rxValid, 0);
        check("arst_busy", busy, 0);
        check("arst_data", rxData_re, 0);
        rst = 1'b1;
        first = -1;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 16'hFFFF);
            if (burst_start && first < 0) first = i;
        end
        check("arst_refill", first, 19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
